// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1/8O1 when UART_RX_PARITY_EN is defined).
// RXD is passed through a two-flop synchroniser. The start bit is confirmed at
// mid-bit. Eight data bits are sampled LSB-first at bit centres, then the stop
// bit is checked. Every good byte is marked by a one-cycle valid strobe.
//
// Optional feature macro: UART_RX_PARITY_EN (adds a PARITY state; see PARITY_ODD).
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   uart_rxd            asynchronous serial input, idles high
//   uart_rx_data        last received byte, updated at every stop-bit sample
//   uart_rx_valid       1-cycle pulse: uart_rx_data holds a good byte
//   uart_rx_busy        high whenever the FSM is not idle
//   uart_rx_frame_err   1-cycle pulse: stop bit sampled low
//   uart_rx_parity_err  1-cycle pulse: parity mismatch (constant 0 without macro)
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] uart_rx_data,
   output logic       uart_rx_valid,
   output logic       uart_rx_busy,
   output logic       uart_rx_frame_err,
   output logic       uart_rx_parity_err
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD 0 or 1");
   end

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StStart    = 3'd1,
      StData     = 3'd2,
      StStop     = 3'd3,
`ifdef UART_RX_PARITY_EN
      StParity   = 3'd5,
`endif
      StWaitHigh = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic            rx_meta_q, rx_s_q, rx_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            par_mismatch;
`ifdef UART_RX_PARITY_EN
   logic            par_bit_q, par_bit_d;
   logic            parity_err_q, parity_err_d;

   // Even parity: the parity bit equals the XOR of the data bits; odd inverts it.
   assign par_mismatch = par_bit_q != ((^shift_q) ^ (PARITY_ODD != 0));
`else
   assign par_mismatch = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CntW'(1);
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d    = par_bit_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (rx_prev_q && !rx_s_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == CntHalf) begin
               idx_d   = 3'd0;
               state_d = rx_s_q ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == CntFull) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               // Same-state bit boundary: restart the bit timer explicitly.
               cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
               if (idx_q == 3'd7) state_d = StParity;
`else
               if (idx_q == 3'd7) state_d = StStop;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (cnt_q == CntFull) begin
               par_bit_d = rx_s_q;
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (cnt_q == CntFull) begin
               // Byte is published even on error so the host can inspect it.
               data_d = shift_q;
`ifdef UART_RX_PARITY_EN
               parity_err_d = par_mismatch;
`endif
               if (rx_s_q) begin
                  valid_d = !par_mismatch;
                  state_d = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StWaitHigh;
               end
            end
         end
         StWaitHigh: begin
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_meta_q   <= uart_rxd;
         rx_s_q      <= rx_meta_q;
         rx_prev_q   <= rx_s_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bit_q    <= par_bit_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign uart_rx_parity_err = parity_err_q;
`else
   assign uart_rx_parity_err = par_mismatch;
`endif

   assign uart_rx_data      = data_q;
   assign uart_rx_valid     = valid_q;
   assign uart_rx_frame_err = frame_err_q;
   assign uart_rx_busy      = state_q != StIdle;

endmodule
